bcd_updown_counter: RTL and testbench
=====================================

# bcd_updown_counter

Parametrised synchronous multi-digit BCD counter, the successor to the single-decade ripple counter. It counts up or down across `DIGITS` decades, with enable, synchronous clear, optional parallel load, terminal-count and wrap outputs. All flops share one clock, so there is no ripple between digits, and digits can be cascaded to any width. It is used as the decimal display/event counter in later assignments.

## Interface
- `DIGITS`, default 4: number of BCD decades (1..8); `count` width is 4*DIGITS.
- `CLK`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `en`  in  1: count enable; one step per enabled cycle.
- `up`  in  1: direction; 1 = increment, 0 = decrement.
- `clr`  in  1: synchronous clear to all-zero.
- `load_en`  in  1: synchronous parallel load (only with `BCD_LOAD_EN`).
- `load_val`  in  4*DIGITS: value to load; digit i is bits [4i+3:4i] (only with `BCD_LOAD_EN`).
- `count`  out  4*DIGITS: registered counter value; digit 0 is the least significant.
- `tc`  out  1: combinational terminal count. It is `en & (up ? all digits == 9 : all digits == 0)`.
- `wrap`  out  1: registered one-cycle pulse; the previous edge wrapped the counter.
- `load_err`  out  1: registered, sticky; a load contained a digit > 9 (only with `BCD_LOAD_EN`).

## Operation
- Reset values: `count` = 0, `wrap` = 0, `load_err` = 0. `tc` follows its equation, so it is 1 during reset only if `en` = 1 and `up` = 0.
- Priority at each edge: `reset` > `clr` > `load_en` > `en` > hold.
- `clr`: `count` ← 0 and `wrap` ← 0. `load_err` ← 0.
- Load:
  - Each digit of `load_val` that is ≤ 9 is taken as-is.
  - A digit > 9 is replaced by 0, and `load_err` ← 1.
  - `wrap` ← 0.
  - `en` is ignored that cycle.
- Up count:
  - Digit i increments when `en` is high and all lower digits are 9.
  - A digit at 9 that increments becomes 0; otherwise it becomes +1.
- Down count:
  - Digit i decrements when `en` is high and all lower digits are 0.
  - A digit at 0 that decrements becomes 9.
- Wrap:
  - Up from all-9s gives all-0s.
  - Down from all-0s gives all-9s.
  - In either case `wrap` ← 1 for exactly one cycle. Otherwise `wrap` ← 0 on every edge.
- Carry/borrow between digits is combinational within one cycle; there is no inter-digit latency.
- `up` may change on any cycle. It only affects the next enabled step.
- `en` low: `count` holds and `wrap` ← 0.
- `load_err` remains 1 until `clr` or `reset`. A later valid load does not clear it.

## Timing
- `count` latency: 1 cycle from an edge sampling `en`/`clr`/`load_en` to the new value on the outputs.
- `wrap` is asserted in the same cycle that `count` shows the wrapped value.
- `tc` is combinational from `count`, `en` and `up`. It is high in the cycle before a wrap, which allows cascading into the `en` of a next stage.
- `reset` asserted mid-count forces all outputs to their reset values without waiting for `CLK`. Counting resumes on the first edge after deassertion if `en` = 1.

## Configuration
- `BCD_LOAD_EN` defined:
  - `load_en`, `load_val` and `load_err` exist.
  - Load behaves as described above.
- `BCD_LOAD_EN` undefined:
  - These three ports and their logic are absent.
  - Priority reduces to `reset` > `clr` > `en`.
  - All other behaviour is identical.

## Structure
- Package `bcd_pkg` holds:
  - `BCD_W` = 4
  - `BCD_MAX` = 4'd9
  - typedef `bcd_digit_t` (logic [3:0])
  - function `bcd_valid(d)`, which returns d ≤ 9
- Sub-module `bcd_digit` is one decade cell, instantiated `DIGITS` times in a generate loop.
  - Inputs: `CLK`, `reset`, `clr`, `load`, `din`, `step`, `up`.
  - Outputs: `q`, `is_max` (q == 9), `is_min` (q == 0).
- The top level forms each digit's `step` from the AND of the lower digits' `is_max`/`is_min` with `en`. It also generates `tc`, `wrap` and `load_err`.

## Test plan
- Reset mid-count: count to 0042, then assert `reset` between edges → `count` = 0000 immediately, `wrap` = 0. Release with `en` = 1 → 0001 after the first edge.
- Up carry, DIGITS = 4: from 0099 with `en` = 1, `up` = 1 → 0100 after one edge. From 9999, `tc` = 1, then next edge → 0000 with `wrap` = 1 for one cycle only.
- Down borrow: from 1000 with `up` = 0 → 0999. From 0000, `tc` = 1, then next edge → 9999 with `wrap` = 1.
- Load priority: `load_en` = 1, `load_val` = 1234, `en` = 1 → 1234, not 1235. Assert `clr` and `load_en` together → 0000.
- Invalid load: `load_val` = 0x12A4 → `count` = 1204, `load_err` = 1. A following valid load of 5678 leaves `load_err` = 1. `clr` → `load_err` = 0.
- Hold and direction change: `en` = 0 for 3 cycles at 0500 → stays 0500 with `wrap` = 0. Toggle `up` each enabled cycle from 0500 → 0501, 0500, 0501.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the multi-decade up/down counter.
//   BCD_W     : bits per decade
//   BCD_MAX   : largest legal decade value
//   bcd_digit_t : one decade
//   bcd_valid : true when a nibble is a legal BCD digit
package bcd_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  function automatic logic bcd_valid(input bcd_digit_t d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade cell. It is cleared, loaded or stepped up or down by one.
// Ports:
//   CLK, reset      : clock, asynchronous active-high reset
//   clr             : synchronous clear (highest synchronous priority)
//   load, din       : synchronous load of din (din is already a legal digit)
//   step, up        : move one position in direction up (1) / down (0)
//   q               : registered digit value
//   is_max, is_min  : q == 9 / q == 0, used to build carry and borrow chains
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       CLK,
  input  logic       reset,
  input  logic       clr,
  input  logic       load,
  input  bcd_digit_t din,
  input  logic       step,
  input  logic       up,
  output bcd_digit_t q,
  output logic       is_max,
  output logic       is_min
);

  bcd_digit_t q_q, q_d;

  // Next digit: clear > load > step > hold, with 9<->0 wrap in either direction
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = din;
    end else if (step) begin
      if (up) begin
        q_d = (q_q == BCD_MAX) ? '0 : q_q + 4'd1;
      end else begin
        q_d = (q_q == '0) ? BCD_MAX : q_q - 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign is_max = (q_q == BCD_MAX);
  assign is_min = (q_q == '0);

endmodule

// File: rtl/bcd_updown_counter.sv
// Synchronous multi-decade BCD up/down counter with no ripple between decades.
// Optional parallel load is compiled in when BCD_LOAD_EN is defined.
// Ports:
//   CLK, reset  : clock, asynchronous active-high reset
//   en, up      : count enable, direction (1 = increment)
//   clr         : synchronous clear of count, wrap and load_err
//   load_en     : synchronous load of load_val (BCD_LOAD_EN only)
//   load_val    : value to load, digit i in bits [4i+3:4i] (BCD_LOAD_EN only)
//   load_err    : sticky flag, a load held a digit > 9 (BCD_LOAD_EN only)
//   count       : registered count, digit 0 least significant
//   tc          : combinational terminal count, high the cycle before a wrap
//   wrap        : registered one-cycle pulse, the last edge wrapped the count
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                en,
  input  logic                up,
  input  logic                clr,
`ifdef BCD_LOAD_EN
  input  logic                load_en,
  input  logic [4*DIGITS-1:0] load_val,
  output logic                load_err,
`endif
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                wrap
);

  localparam int unsigned CW = BCD_W * DIGITS;

  logic [DIGITS-1:0] is_max, is_min, step;
  logic [DIGITS:0]   max_chain, min_chain;
  logic              load;
  logic [CW-1:0]     din;
  logic              wrap_q, wrap_d;

`ifdef BCD_LOAD_EN
  logic any_bad;
  logic load_err_q, load_err_d;

  // Illegal digits load as 0 and raise the sticky error flag
  always_comb begin
    din     = '0;
    any_bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_valid(load_val[i*BCD_W +: BCD_W])) begin
        din[i*BCD_W +: BCD_W] = load_val[i*BCD_W +: BCD_W];
      end else begin
        any_bad = 1'b1;
      end
    end
  end

  assign load = load_en;

  always_comb begin
    load_err_d = load_err_q;
    if (clr) begin
      load_err_d = 1'b0;
    end else if (load_en && any_bad) begin
      load_err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_err_d;
    end
  end

  assign load_err = load_err_q;
`else
  assign load = 1'b0;
  assign din  = '0;
`endif

  // Carry/borrow chains: digit i steps when every lower digit is at 9 (up) or 0 (down)
  always_comb begin
    max_chain    = '0;
    min_chain    = '0;
    step         = '0;
    max_chain[0] = 1'b1;
    min_chain[0] = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      max_chain[i+1] = max_chain[i] & is_max[i];
      min_chain[i+1] = min_chain[i] & is_min[i];
      step[i]        = en & (up ? max_chain[i] : min_chain[i]);
    end
    tc     = en & (up ? max_chain[DIGITS] : min_chain[DIGITS]);
    // A terminal-count step wraps unless clear or load take priority
    wrap_d = tc & ~clr & ~load;
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .CLK    (CLK),
      .reset  (reset),
      .clr    (clr),
      .load   (load),
      .din    (din[g*BCD_W +: BCD_W]),
      .step   (step[g]),
      .up     (up),
      .q      (count[g*BCD_W +: BCD_W]),
      .is_max (is_max[g]),
      .is_min (is_min[g])
    );
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench for bcd_updown_counter (DIGITS = 4).
// The reference model holds the count as a plain decimal integer.
module tb_bcd_updown_counter;

  localparam int unsigned DIGITS = 4;
  localparam int          MOD    = 10000;

  logic        CLK = 1'b0;
  logic        reset, en, up, clr;
  logic [15:0] count;
  logic        tc, wrap;
`ifdef BCD_LOAD_EN
  logic        load_en;
  logic [15:0] load_val;
  logic        load_err;
`endif

  int   checks   = 0;
  int   failures = 0;
  int   m_val    = 0;
  logic m_wrap   = 1'b0;
  logic m_err    = 1'b0;

  typedef struct {
    logic        clr;
    logic        en;
    logic        up;
    logic        exp_tc;
    logic [15:0] exp_count;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[12];

  always #5 CLK = ~CLK;

  bcd_updown_counter #(.DIGITS(DIGITS)) dut (
    .CLK      (CLK),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .clr      (clr),
`ifdef BCD_LOAD_EN
    .load_en  (load_en),
    .load_val (load_val),
    .load_err (load_err),
`endif
    .count    (count),
    .tc       (tc),
    .wrap     (wrap)
  );

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'((v / (10 ** i)) % 10);
    end
    return r;
  endfunction

  function automatic logic model_tc();
    return en && (up ? (m_val == MOD - 1) : (m_val == 0));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal model of one clock edge using the current inputs
  task automatic model_edge();
    m_wrap = 1'b0;
    if (clr) begin
      m_val = 0;
      m_err = 1'b0;
    end
`ifdef BCD_LOAD_EN
    else if (load_en) begin
      int v;
      int d;
      v = 0;
      for (int i = 0; i < 4; i++) begin
        d = int'(load_val[i*4 +: 4]);
        if (d > 9) begin
          d     = 0;
          m_err = 1'b1;
        end
        v += d * (10 ** i);
      end
      m_val = v;
    end
`endif
    else if (en) begin
      if (up) begin
        m_wrap = (m_val == MOD - 1);
        m_val  = (m_val + 1) % MOD;
      end else begin
        m_wrap = (m_val == 0);
        m_val  = (m_val + MOD - 1) % MOD;
      end
    end
  endtask

  // One clock with current inputs, checked against the model
  task automatic cycle(input string name);
    #1;
    chk({name, ".tc"}, 32'(tc), 32'(model_tc()));
    @(posedge CLK);
    model_edge();
    #1;
    chk({name, ".count"}, 32'(count), 32'(to_bcd(m_val)));
    chk({name, ".wrap"}, 32'(wrap), 32'(m_wrap));
`ifdef BCD_LOAD_EN
    chk({name, ".load_err"}, 32'(load_err), 32'(m_err));
`endif
  endtask

  task automatic run_up(input int n);
    en  = 1'b1;
    up  = 1'b1;
    clr = 1'b0;
    repeat (n) cycle("run");
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cycle("clr");
    clr = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0002, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h9999, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h9999, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h9999, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h9998, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0};

    reset = 1'b1;
    en    = 1'b1;
    up    = 1'b0;
    clr   = 1'b0;
`ifdef BCD_LOAD_EN
    load_en  = 1'b0;
    load_val = '0;
`endif
    #2;
    chk("reset.count", 32'(count), 32'h0);
    chk("reset.wrap", 32'(wrap), 32'h0);
    chk("reset.tc_down", 32'(tc), 32'h1);
`ifdef BCD_LOAD_EN
    chk("reset.load_err", 32'(load_err), 32'h0);
`endif
    up = 1'b1;
    #1;
    chk("reset.tc_up", 32'(tc), 32'h0);
    en    = 1'b0;
    reset = 1'b0;
    cycle("post_reset");

    // Table-driven vectors from 0000
    for (int i = 0; i < 12; i++) begin
      clr = vecs[i].clr;
      en  = vecs[i].en;
      up  = vecs[i].up;
      #1;
      chk($sformatf("vec%0d.tc", i), 32'(tc), 32'(vecs[i].exp_tc));
      @(posedge CLK);
      model_edge();
      #1;
      chk($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d.wrap", i), 32'(wrap), 32'(vecs[i].exp_wrap));
    end
    clr = 1'b0;

    // Asynchronous reset in the middle of a cycle
    run_up(42);
    chk("pre_reset.count", 32'(count), 32'h0042);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset.count", 32'(count), 32'h0);
    chk("async_reset.wrap", 32'(wrap), 32'h0);
    m_val  = 0;
    m_wrap = 1'b0;
    m_err  = 1'b0;
    #1;
    reset = 1'b0;
    en    = 1'b1;
    up    = 1'b1;
    cycle("after_reset");
    chk("after_reset.first", 32'(count), 32'h0001);

    // Up carry across two decades, then up-wrap
    do_clr();
    run_up(99);
    chk("carry.0099", 32'(count), 32'h0099);
    cycle("carry");
    chk("carry.0100", 32'(count), 32'h0100);
    do_clr();
    up = 1'b0;
    cycle("to_9999");
    chk("to_9999.count", 32'(count), 32'h9999);
    up = 1'b1;
    #1;
    chk("tc_at_9999", 32'(tc), 32'h1);
    cycle("up_wrap");
    chk("up_wrap.count", 32'(count), 32'h0000);
    chk("up_wrap.wrap", 32'(wrap), 32'h1);
    en = 1'b0;
    cycle("wrap_drop");
    chk("wrap_one_cycle", 32'(wrap), 32'h0);

    // Down borrow across three decades, then down-wrap
    do_clr();
    run_up(1000);
    chk("borrow.1000", 32'(count), 32'h1000);
    up = 1'b0;
    cycle("borrow");
    chk("borrow.0999", 32'(count), 32'h0999);
    do_clr();
    en = 1'b1;
    up = 1'b0;
    #1;
    chk("tc_at_0000", 32'(tc), 32'h1);
    cycle("down_wrap");
    chk("down_wrap.count", 32'(count), 32'h9999);
    chk("down_wrap.wrap", 32'(wrap), 32'h1);

    // Hold, then direction change on every enabled cycle
    do_clr();
    run_up(500);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle("hold");
      chk("hold.count", 32'(count), 32'h0500);
      chk("hold.wrap", 32'(wrap), 32'h0);
    end
    en = 1'b1;
    up = 1'b1;
    cycle("dir0");
    chk("dir0.count", 32'(count), 32'h0501);
    up = 1'b0;
    cycle("dir1");
    chk("dir1.count", 32'(count), 32'h0500);
    up = 1'b1;
    cycle("dir2");
    chk("dir2.count", 32'(count), 32'h0501);

`ifdef BCD_LOAD_EN
    // Load priority and invalid-digit handling
    en       = 1'b1;
    up       = 1'b1;
    load_en  = 1'b1;
    load_val = 16'h1234;
    cycle("load");
    chk("load.count", 32'(count), 32'h1234);
    chk("load.err", 32'(load_err), 32'h0);
    clr = 1'b1;
    cycle("clr_over_load");
    chk("clr_over_load.count", 32'(count), 32'h0000);
    clr      = 1'b0;
    load_val = 16'h12A4;
    cycle("bad_load");
    chk("bad_load.count", 32'(count), 32'h1204);
    chk("bad_load.err", 32'(load_err), 32'h1);
    load_val = 16'h5678;
    cycle("good_load");
    chk("good_load.count", 32'(count), 32'h5678);
    chk("good_load.err_sticky", 32'(load_err), 32'h1);
    load_en = 1'b0;
    clr     = 1'b1;
    cycle("clr_err");
    chk("clr_err.err", 32'(load_err), 32'h0);
    clr = 1'b0;
`endif

    // Randomized stimulus against the decimal model
    for (int i = 0; i < 3000; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      up  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 63) == 0);
`ifdef BCD_LOAD_EN
      load_en  = ($urandom_range(0, 31) == 0);
      load_val = 16'($urandom);
`endif
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
